// File: rtl/cpu_pkg.sv
// Shared encodings for the accumulator CPU sequencer: opcodes, phases,
// ALU operation codes and the sequencer run-state.
package cpu_pkg;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    localparam logic [2:0] P_INST_ADDR  = 3'd0;
    localparam logic [2:0] P_INST_FETCH = 3'd1;
    localparam logic [2:0] P_INST_LOAD  = 3'd2;
    localparam logic [2:0] P_IDLE       = 3'd3;
    localparam logic [2:0] P_OP_ADDR    = 3'd4;
    localparam logic [2:0] P_OP_FETCH   = 3'd5;
    localparam logic [2:0] P_ALU_OP     = 3'd6;
    localparam logic [2:0] P_STORE      = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_AND  = 2'b01;
    localparam logic [1:0] ALU_XOR  = 2'b10;
    localparam logic [1:0] ALU_PASS = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_WAIT   = 2'd2
    } seq_state_e;

    // Opcodes that read an operand from memory and load ACC.
    function automatic logic is_aluop(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) || (op == OP_LDA);
    endfunction

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR);
    endfunction

    function automatic logic [1:0] alu_op_of(input logic [2:0] op);
        logic [1:0] r;
        case (op)
            OP_ADD:  r = ALU_ADD;
            OP_AND:  r = ALU_AND;
            OP_XOR:  r = ALU_XOR;
            default: r = ALU_PASS;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cpu_phase_decode.sv
// Combinational decode of (phase, state, opcode, zero_q) into datapath strobes.
// Kept free of state so the whole table can be swept on its own.
module cpu_phase_decode
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3
) (
    input  logic [2:0]          phase,
    input  logic [1:0]          state,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                zero_q,
    output logic                addr_sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                acc_ld,
    output logic                alu_to_acc,
    output logic [1:0]          alu_op,
    output logic                halted
);

    logic [2:0] op;
    logic       op_alu;
    logic       op_arith;
    logic       op_skz;
    logic       op_sto;
    logic       op_jmp;

    assign op       = 3'(opcode);
    assign op_alu   = is_aluop(op);
    assign op_arith = is_arith(op);
    assign op_skz   = (op == OP_SKZ);
    assign op_sto   = (op == OP_STO);
    assign op_jmp   = (op == OP_JMP);

    assign halted = (state == ST_HALTED);

    always_comb begin
        addr_sel   = 1'b1;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        ir_ld      = 1'b0;
        pc_inc     = 1'b0;
        pc_ld      = 1'b0;
        acc_ld     = 1'b0;
        alu_to_acc = 1'b0;
        alu_op     = ALU_PASS;

        // HALTED and WAIT keep the bus pointed at PC with every strobe idle.
        if (state == ST_RUN) begin
            case (phase)
                P_INST_ADDR: begin
                    addr_sel = 1'b1;
                end
                P_INST_FETCH: begin
                    mem_rd = 1'b1;
                end
                P_INST_LOAD, P_IDLE: begin
                    mem_rd = 1'b1;
                    ir_ld  = 1'b1;
                end
                P_OP_ADDR: begin
                    addr_sel = 1'b0;
                    pc_inc   = 1'b1;
                end
                P_OP_FETCH: begin
                    addr_sel = 1'b0;
                    mem_rd   = op_alu;
                end
                P_ALU_OP: begin
                    addr_sel = 1'b0;
                    mem_rd   = op_alu;
                    pc_inc   = op_skz & zero_q;
                    pc_ld    = op_jmp;
                end
                P_STORE: begin
                    addr_sel = 1'b0;
                    mem_rd   = op_alu;
                    acc_ld   = op_alu;
                    pc_ld    = op_jmp;
                    mem_wr   = op_sto;
                end
                default: begin
                    addr_sel = 1'b1;
                end
            endcase

            // ALU select is only meaningful once the operand cycle begins.
            if (phase[2]) begin
                alu_op     = alu_op_of(op);
                alu_to_acc = op_arith;
            end
        end
    end

endmodule

// File: rtl/cpu_phase_sequencer.sv
// Eight-phase fetch/execute sequencer with halt/resume and single-step control.
// Holds phase, run-state and the sampled zero flag; decode is delegated.
module cpu_phase_sequencer
    import cpu_pkg::*;
#(
    parameter int OPCODE_W = 3,
    parameter bit STEP_EN  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                acc_zero,
    input  logic                resume,
    input  logic                step_mode,
    input  logic                step,
    output logic                addr_sel,
    output logic                mem_rd,
    output logic                mem_wr,
    output logic                ir_ld,
    output logic                pc_inc,
    output logic                pc_ld,
    output logic                acc_ld,
    output logic                alu_to_acc,
    output logic [1:0]          alu_op,
    output logic                halted,
    output logic [2:0]          phase,
    output logic [1:0]          seq_state
);

    seq_state_e state_q, state_d;
    logic [2:0] phase_q, phase_d;
    logic       zero_q, zero_d;
    logic       step_mode_en;
    logic [2:0] op;

    assign op           = 3'(opcode);
    assign step_mode_en = STEP_EN && step_mode;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            phase_q <= P_INST_ADDR;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            zero_q  <= zero_d;
        end
    end

    // Handshake: resume and step are single-cycle pulses, each sampled only in
    // its own waiting state (HALTED / WAIT) and ignored elsewhere; halted is
    // the status the debugger watches before issuing resume.
    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        zero_d  = zero_q;
        case (state_q)
            ST_RUN: begin
                phase_d = phase_q + 3'd1;
                if (phase_q == P_OP_FETCH) begin
                    zero_d = acc_zero;
                end
                // The wrap 4 -> 5 already leaves phase at 5 for the halt.
                if ((phase_q == P_OP_ADDR) && (op == OP_HLT)) begin
                    state_d = ST_HALTED;
                end
                if ((phase_q == P_STORE) && step_mode_en) begin
                    state_d = ST_WAIT;
                end
            end
            ST_HALTED: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_WAIT: begin
                if (step || !step_mode_en) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                phase_d = P_INST_ADDR;
            end
        endcase
    end

    assign phase     = phase_q;
    assign seq_state = state_q;

    cpu_phase_decode #(
        .OPCODE_W (OPCODE_W)
    ) u_decode (
        .phase      (phase_q),
        .state      (state_q),
        .opcode     (opcode),
        .zero_q     (zero_q),
        .addr_sel   (addr_sel),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .ir_ld      (ir_ld),
        .pc_inc     (pc_inc),
        .pc_ld      (pc_ld),
        .acc_ld     (acc_ld),
        .alu_to_acc (alu_to_acc),
        .alu_op     (alu_op),
        .halted     (halted)
    );

endmodule
